// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, free-running H/V counters, sync/blank
// decode and a latency-matched output stage merging drawing-logic colour or test patterns.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CLK_DIV   = 2,
    parameter int   PIPE      = 2,
    parameter int   COORD_W   = 10,
    parameter int   COLOR_W   = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic                   pix_ce,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic                   coord_valid,
    output logic                   frame_start,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic [COLOR_W-1:0]     VGA_R,
    output logic [COLOR_W-1:0]     VGA_G,
    output logic [COLOR_W-1:0]     VGA_B,
    output logic                   VGA_CLK,
    output logic                   VGA_SYNC_N
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int BAR_PIX = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [COORD_W-1:0] BAR_W_C  = COORD_W'(BAR_PIX);

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [2:0] bar;
        logic       chk;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, bar: 3'd0, chk: 1'b0};

    logic [DIV_W-1:0]   div_q, div_d;
    logic               vga_clk_q;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic               valid_q, fs_q, hs_act_q, vs_act_q;
    logic [1:0]         mode_q;
    logic [COORD_W-1:0] bar_idx;
    logic [2:0]         bar_k;
    pix_t               s0, tail;
    logic [3*COLOR_W-1:0] colour_d, rgb_q;
    logic               hs_q, vs_q, blank_n_q, hs_d, vs_d;

    assign pix_ce = (div_q == DIV_LAST);

    always_comb begin
        div_d = pix_ce ? '0 : div_q + DIV_W'(1);
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
            end else begin
                h_d = h_q + COORD_W'(1);
            end
        end
    end

    // Stage 0 captures the counter before it advances, so x/y lag h/v by one tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            hs_act_q  <= 1'b0;
            vs_act_q  <= 1'b0;
            mode_q    <= 2'd0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= (div_d >= DIV_HALF);
            h_q       <= h_d;
            v_q       <= v_d;
            if (pix_ce) begin
                x_q      <= h_q;
                y_q      <= v_q;
                valid_q  <= (h_q < H_VIS) && (v_q < V_VIS);
                fs_q     <= (h_q == '0) && (v_q == '0);
                hs_act_q <= (h_q >= HS_BEG) && (h_q < HS_END);
                vs_act_q <= (v_q >= VS_BEG) && (v_q < VS_END);
                if (fs_q) begin
                    mode_q <= mode;
                end
            end
        end
    end

    assign bar_idx = x_q / BAR_W_C;
    assign bar_k   = (bar_idx > COORD_W'(7)) ? 3'd7 : bar_idx[2:0];

    always_comb begin
        s0       = PIX_IDLE;
        s0.hs    = hs_act_q;
        s0.vs    = vs_act_q;
        s0.blank = ~valid_q;
        s0.bar   = bar_k;
        s0.chk   = x_q[5] ^ y_q[5];
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            assign tail = s0;
        end else begin : g_pipe
            pix_t pipe_q [PIPE];
            pix_t pipe_d [PIPE];
            for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign pipe_d[gi] = pix_ce ? s0 : pipe_q[gi];
                end else begin : g_body
                    assign pipe_d[gi] = pix_ce ? pipe_q[gi-1] : pipe_q[gi];
                end
            end
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= PIX_IDLE;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end
            assign tail = pipe_q[PIPE-1];
        end
    endgenerate

    always_comb begin
        colour_d = '0;
        if (!tail.blank) begin
            case (mode_q)
                2'd0:    colour_d = rgb_in;
                2'd1:    colour_d = {{COLOR_W{tail.bar[2]}}, {COLOR_W{tail.bar[1]}},
                                     {COLOR_W{tail.bar[0]}}};
                2'd2:    colour_d = {(3*COLOR_W){tail.chk}};
                default: colour_d = '1;
            endcase
        end
        hs_d = tail.hs ? HS_POL : ~HS_POL;
        vs_d = tail.vs ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else if (pix_ce) begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= ~tail.blank;
            rgb_q     <= colour_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign coord_valid = valid_q;
    assign frame_start = fs_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign VGA_G       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B       = rgb_q[COLOR_W-1 -: COLOR_W];
    assign VGA_CLK     = vga_clk_q;
    assign VGA_SYNC_N  = 1'b0;
endmodule
